// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: state encoding,
// default memory depth, reset fetch vector and the word-range helper.
package imem_arb_pkg;

  localparam int unsigned ROM_SIZE_DEF = 256;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  // Word index is the byte address with bit 31 and the byte offset stripped.
  function automatic logic in_range(input logic [28:0] idx, input int unsigned size);
    return ({3'b000, idx} < size);
  endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Bus bundle between the arbiter, its two requesters and the single-port memory.
interface imem_arb_if #(
  parameter int AW = 8
);
  logic          boot_done;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  boot_done, f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output boot_done, f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arb_age.sv
// Loader starvation counter: counts consecutive refused loader cycles in RUN
// and flags when the loader must be forced through.
module imem_arb_age #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_l_req,
  input  logic i_l_gnt,
  output logic o_force
);

  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (!i_l_req || i_l_gnt) begin
      r_wait_cnt <= '0;
    end else if (i_run && (r_wait_cnt != CW'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  assign o_force = (r_wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/imem_arb.sv
// Arbiter sharing one single-port instruction memory between CPU fetch and a
// loader; loader owns the memory during boot, fetch has priority afterwards.
//
//   state   | meaning
//   ST_BOOT | loader granted whenever it requests, fetch held off
//   ST_RUN  | fetch by default, loader when fetch idle or starved
module imem_arb
  import imem_arb_pkg::*;
#(
  parameter int ROM_SIZE = ROM_SIZE_DEF,
  parameter int MAX_WAIT = 4,
  parameter int AW       = $clog2(ROM_SIZE)
) (
  input  logic       clk,
  input  logic       reset,
  imem_arb_if.slave  bus
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic        w_run;
  logic        w_force;
  logic        w_f_gnt;
  logic        w_l_gnt;
  logic        w_f_acc;
  logic        w_l_acc;
  logic        w_in_range;
  logic [31:0] w_addr;
  logic [28:0] w_idx;
  logic        r_rsp_f;
  logic        r_rsp_l;
  logic        r_rsp_oor;
  logic        w_unused_bits;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    w_state_nxt = r_state;
    w_f_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    if (reset) begin
      case (r_state)
        ST_BOOT: begin
          w_l_gnt = bus.l_req;
          if (bus.boot_done) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.l_req && (!bus.f_req || w_force)) begin
            w_l_gnt = 1'b1;
          end else begin
            w_f_gnt = bus.f_req;
          end
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  imem_arb_age #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .reset   (reset),
    .i_run   (w_run),
    .i_l_req (bus.l_req),
    .i_l_gnt (w_l_gnt),
    .o_force (w_force)
  );

  assign w_f_acc    = bus.f_req & w_f_gnt;
  assign w_l_acc    = bus.l_req & w_l_gnt;
  assign w_addr     = w_l_gnt ? bus.l_addr : bus.f_addr;
  assign w_idx      = w_addr[30:2];
  assign w_in_range = in_range(w_idx, ROM_SIZE);

  assign bus.f_gnt   = w_f_gnt;
  assign bus.l_gnt   = w_l_gnt;
  assign bus.m_en    = (w_f_acc | w_l_acc) & w_in_range;
  assign bus.m_we    = w_l_acc & bus.l_we & w_in_range;
  assign bus.m_addr  = w_idx[AW-1:0];
  assign bus.m_wdata = w_l_acc ? bus.l_wdata : 32'h0;

  // Owner and range are captured at acceptance so a grant in the response
  // cycle can reuse the memory without disturbing the returning data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_f   <= 1'b0;
      r_rsp_l   <= 1'b0;
      r_rsp_oor <= 1'b0;
    end else begin
      r_rsp_f   <= w_f_acc;
      r_rsp_l   <= w_l_acc & ~bus.l_we;
      r_rsp_oor <= ~w_in_range;
    end
  end

  assign bus.f_rvalid = r_rsp_f;
  assign bus.l_rvalid = r_rsp_l;
  assign bus.f_rdata  = (r_rsp_f && !r_rsp_oor) ? bus.m_rdata : 32'h0;
  assign bus.l_rdata  = (r_rsp_l && !r_rsp_oor) ? bus.m_rdata : 32'h0;

  assign w_unused_bits = ^{w_addr[31], w_addr[1:0]};

endmodule

// File: tb/tb_imem_arb.sv
// Self-checking bench for imem_arb: directed boot/run scenarios plus random
// traffic, compared against a transaction-level model with a shadow memory.
module tb_imem_arb;
  import imem_arb_pkg::*;

  localparam int RS = 256;
  localparam int MW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lg_seen;

  // reference model state
  bit          mode_run;
  int          refusals;
  int          pend_owner;   // 0 none, 1 fetch, 2 loader
  logic [31:0] pend_data;
  logic [31:0] shadow [0:RS-1];

  // memory environment
  logic [31:0] ram [0:RS-1];
  logic [31:0] mem_q;

  imem_arb_if #(.AW(8)) bus ();

  imem_arb #(
    .ROM_SIZE (RS),
    .MAX_WAIT (MW)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr] <= bus.m_wdata;
      else          mem_q <= ram[bus.m_addr];
    end
  end
  assign bus.m_rdata = mem_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit bd, input bit fr, input logic [31:0] fa,
                        input bit lr, input bit lw, input logic [31:0] la,
                        input logic [31:0] ld);
    bus.boot_done = bd;
    bus.f_req     = fr;
    bus.f_addr    = fa;
    bus.l_req     = lr;
    bus.l_we      = lw;
    bus.l_addr    = la;
    bus.l_wdata   = ld;
  endtask

  // Called just after a negedge with inputs applied; checks, advances the
  // model and returns at the next negedge.
  task automatic do_cycle();
    bit          lg, fg, inr, rd, wr;
    logic [31:0] a;
    int          idx;
    logic [31:0] rd_val;
    #2;
    if (!rst) begin
      mode_run   = 0;
      refusals   = 0;
      pend_owner = 0;
      pend_data  = 0;
      chk("rst_f_gnt",    32'(bus.f_gnt),    0);
      chk("rst_l_gnt",    32'(bus.l_gnt),    0);
      chk("rst_f_rvalid", 32'(bus.f_rvalid), 0);
      chk("rst_l_rvalid", 32'(bus.l_rvalid), 0);
      chk("rst_m_en",     32'(bus.m_en),     0);
      chk("rst_m_we",     32'(bus.m_we),     0);
      chk("rst_f_rdata",  bus.f_rdata,       0);
      chk("rst_l_rdata",  bus.l_rdata,       0);
    end else begin
      if (!mode_run) begin
        lg = bus.l_req;
        fg = 0;
      end else begin
        lg = bus.l_req && (!bus.f_req || refusals >= MW);
        fg = bus.f_req && !lg;
      end
      a   = lg ? bus.l_addr : bus.f_addr;
      idx = int'((a & 32'h7fff_ffff) >> 2);
      inr = (idx < RS);
      wr  = lg && bus.l_we;
      rd  = fg || (lg && !bus.l_we);
      chk("f_gnt", 32'(bus.f_gnt), 32'(fg));
      chk("l_gnt", 32'(bus.l_gnt), 32'(lg));
      chk("m_en",  32'(bus.m_en),  32'((lg || fg) && inr));
      chk("m_we",  32'(bus.m_we),  32'(wr && inr));
      if ((lg || fg) && inr) chk("m_addr",  32'(bus.m_addr), 32'(idx));
      if (wr && inr)         chk("m_wdata", bus.m_wdata, bus.l_wdata);
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(pend_owner == 1));
      chk("f_rdata",  bus.f_rdata, (pend_owner == 1) ? pend_data : 32'h0);
      chk("l_rvalid", 32'(bus.l_rvalid), 32'(pend_owner == 2));
      chk("l_rdata",  bus.l_rdata, (pend_owner == 2) ? pend_data : 32'h0);
      if (bus.l_gnt) lg_seen++;
      rd_val     = inr ? shadow[idx] : 32'h0;
      pend_owner = rd ? (lg ? 2 : 1) : 0;
      pend_data  = rd_val;
      if (wr && inr) shadow[idx] = bus.l_wdata;
      if (mode_run && bus.l_req && !lg) refusals = (refusals + 1 > MW) ? MW : refusals + 1;
      else                              refusals = 0;
      if (!mode_run && bus.boot_done) mode_run = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1, 2, 3, 4, 5: return ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      6:       return 32'h400 + ($urandom_range(0, 7) << 2);
      7:       return 32'h8000_0000 | ($urandom_range(0, 15) << 2);
      8:       return $urandom;
      default: return 32'h3FC;
    endcase
  endfunction

  initial begin
    total      = 0;
    bad        = 0;
    lg_seen    = 0;
    mode_run   = 0;
    refusals   = 0;
    pend_owner = 0;
    pend_data  = 0;
    mem_q      = 0;
    for (int i = 0; i < RS; i++) begin
      shadow[i] = 0;
      ram[i]    = 0;
    end
    rst = 1'b0;
    set_in(0, 1, 32'h0, 1, 1, 32'h0, 32'h1234);
    @(negedge clk);
    repeat (3) do_cycle();

    // boot: loader preloads, fetch is held off
    rst = 1'b1;
    set_in(0, 1, RESET_VECTOR, 1, 1, 32'h0, 32'h0800_0003); do_cycle();
    set_in(0, 1, RESET_VECTOR, 1, 1, 32'h4, 32'h1111_1111); do_cycle();
    set_in(0, 0, 32'h0, 1, 1, 32'h8, 32'h2222_2222);        do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);                do_cycle();
    set_in(1, 1, 32'h0, 1, 1, 32'hC, 32'h3333_3333);        do_cycle();

    // run: fetch of the reset vector returns the preloaded word
    set_in(0, 1, RESET_VECTOR, 0, 0, 32'h0, 32'h0); do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);        do_cycle();

    // continuous contention: loader gets through once per MW+1 cycles
    lg_seen = 0;
    set_in(0, 1, 32'h10, 1, 0, 32'h8, 32'h0);
    repeat (3 * (MW + 1)) do_cycle();
    chk("contention_l_gnt_count", 32'(lg_seen), 32'd3);
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); do_cycle();

    // out-of-range fetch and dropped out-of-range write
    set_in(0, 1, 32'h400, 0, 0, 32'h0, 32'h0);          do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);            do_cycle();
    set_in(0, 0, 32'h0, 1, 1, 32'h400, 32'hDEAD_BEEF);  do_cycle();
    set_in(0, 1, 32'h0, 0, 0, 32'h0, 32'h0);            do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);            do_cycle();

    // back-to-back fetch then loader read
    set_in(0, 1, 32'h4, 0, 0, 32'h0, 32'h0); do_cycle();
    set_in(0, 0, 32'h0, 1, 0, 32'h8, 32'h0); do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); do_cycle();

    // random traffic
    repeat (400) begin
      set_in(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), pick_addr(),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), pick_addr(), $urandom);
      do_cycle();
    end

    // reset right after an accepted read discards the response
    set_in(0, 1, 32'h8, 0, 0, 32'h0, 32'h0); do_cycle();
    rst = 1'b0;
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); do_cycle();
    do_cycle();
    rst = 1'b1;
    set_in(0, 1, 32'h0, 0, 0, 32'h0, 32'h0); do_cycle();
    do_cycle();
    set_in(0, 1, 32'h0, 1, 0, 32'h4, 32'h0); do_cycle();
    set_in(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); do_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive refused loader cycles before the loader is forced priority.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port boot_done  input  1  one-cycle pulse ending boot mode.
REQ-006 SHALL have port f_req  input  1  CPU fetch read request.
REQ-007 SHALL have port f_addr  input  32  CPU fetch byte address.
REQ-008 SHALL have ports f_gnt  output  1, f_rvalid  output  1, f_rdata  output  32  fetch grant, response valid, response data.
REQ-009 SHALL have ports l_req  input  1, l_we  input  1, l_addr  input  32, l_wdata  input  32  loader request, write enable, byte address, write data.
REQ-010 SHALL have ports l_gnt  output  1, l_rvalid  output  1, l_rdata  output  32  loader grant, response valid, response data.
REQ-011 SHALL have ports m_en  output  1, m_we  output  1, m_addr  output  8 (clog2 ROM_SIZE), m_wdata  output  32, m_rdata  input  32  single-port synchronous memory with one-cycle read latency.

Function
REQ-012 SHALL implement states BOOT and RUN; reset enters BOOT; BOOT->RUN on boot_done; RUN has no exit other than reset.
REQ-013 In BOOT, SHALL hold f_gnt=0 and grant l_req every cycle it is asserted.
REQ-014 In RUN, SHALL grant exactly one requester per cycle: fetch by default, loader when f_req=0 or when wait_cnt==MAX_WAIT.
REQ-015 SHALL increment wait_cnt (saturating at MAX_WAIT) each RUN cycle l_req=1 and l_gnt=0, and clear it on any loader grant or when l_req=0.
REQ-016 Grant SHALL be combinational from current requests and state; a request is accepted in the cycle req&gnt=1.
REQ-017 Word index SHALL be addr[30:2]; an address is in range iff addr[30:2] < ROM_SIZE.
REQ-018 On an accepted in-range request, SHALL drive m_en=1, m_addr=addr[30:2], m_we=l_we (0 for fetch), m_wdata=l_wdata in the same cycle.
REQ-019 On an accepted out-of-range request, SHALL drive m_en=0; writes are dropped, reads return 32'h0.
REQ-020 Exactly one cycle after an accepted read, SHALL pulse the owner's rvalid for one cycle with rdata=m_rdata (or 0 if out of range); accepted writes produce no rvalid.
REQ-021 SHALL register response owner and out-of-range flag at acceptance so a new grant in the response cycle does not corrupt routing (back-to-back throughput 1 per cycle).
REQ-022 f_rdata/l_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-023 boot_done coincident with a loader request SHALL still grant the loader in that cycle; RUN rules apply from the next cycle.

Reset
REQ-024 While reset=0: state=BOOT, wait_cnt=0, response-valid registers=0, all gnt/rvalid/m_en/m_we=0, all rdata=0.
REQ-025 Reset asserted mid-transaction SHALL discard any pending response; no rvalid after release until a new accepted read.

Structure
REQ-026 State encodings, ROM_SIZE default and the 0x00000000 reset fetch vector SHALL live in the shared cpu package.
REQ-027 wait_cnt starvation counter SHALL be the sub-module imem_arb_age; all else flat.

Verification
REQ-028 Reset release, l_req write addr 0x0 data 0x08000003, then boot_done -> m_we=1 m_addr=0; f_gnt=0 before boot_done.
REQ-029 RUN, f_req read 0x0 -> f_rvalid next cycle, f_rdata=0x08000003, l_rvalid=0.
REQ-030 RUN, f_req and l_req held continuously -> l_gnt exactly once per MAX_WAIT+1 cycles (cycle 5 with default).
REQ-031 Fetch read 0x00000400 (index 256) -> m_en=0, f_rvalid=1, f_rdata=0; loader write there -> no memory write.
REQ-032 Back-to-back fetch 0x4 then loader read 0x8 -> rvalids on consecutive cycles to correct owners with correct data.
REQ-033 Reset asserted the cycle after an accepted read -> no rvalid; state=BOOT after release.
